// File: rtl/alu_dispatch.sv
// Issue stage in front of the level-sensitive 64-bit ALU: queues {op,a,b} requests, holds each
// one on the ALU for SETTLE cycles, then registers c/flags behind a valid/ready result slot.

module alu_dispatch_checker #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          in_ready,
  input logic [CW-1:0] count,
  input logic          alu_enable,
  input logic [63:0]   alu_a,
  input logic [63:0]   alu_b,
  input logic [5:0]    alu_op,
  input logic          out_valid,
  input logic          out_ready
);
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH));

  a_ready_is_not_full: assert property (@(posedge clk) disable iff (rst)
    in_ready == (count != CW'(DEPTH)));

  // Back-to-back enabled cycles always belong to the same request.
  a_operands_stable: assert property (@(posedge clk) disable iff (rst)
    (alu_enable && $past(alu_enable)) |-> ($stable(alu_a) && $stable(alu_b) && $stable(alu_op)));

  a_slot_held: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> out_valid);
endmodule

module alu_dispatch #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             in_op,
  input  logic [63:0]            in_a,
  input  logic [63:0]            in_b,
  input  logic                   flush,
  output logic [63:0]            alu_a,
  output logic [63:0]            alu_b,
  output logic [5:0]             alu_op,
  output logic                   alu_enable,
  input  logic [31:0]            alu_c,
  input  logic [6:0]             alu_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_c,
  output logic [6:0]             out_flags,
  output logic [5:0]             out_op,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  logic [5:0]    op_mem_r [DEPTH];
  logic [63:0]   a_mem_r  [DEPTH];
  logic [63:0]   b_mem_r  [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  state_t        state_r;
  state_t        state_s;
  logic [3:0]    cnt_r;
  logic [63:0]   alu_a_r;
  logic [63:0]   alu_b_r;
  logic [5:0]    alu_op_r;

  logic          out_valid_r;
  logic [31:0]   out_c_r;
  logic [6:0]    out_flags_r;
  logic [5:0]    out_op_r;

  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          capture_s;
  logic          slot_free_s;

  // A flush discards any push arriving in the same cycle.
  assign full_s      = (count_r == CW'(DEPTH));
  assign push_s      = in_valid & ~full_s & ~flush;
  assign slot_free_s = ~out_valid_r | out_ready;

  // Request storage; no reset needed since count_r gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      op_mem_r[wr_ptr_r] <= in_op;
      a_mem_r[wr_ptr_r]  <= in_a;
      b_mem_r[wr_ptr_r]  <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, pop and capture decisions.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!flush && (count_r != {CW{1'b0}}) && slot_free_s) begin
          pop_s   = 1'b1;
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (flush) begin
          state_s = IDLE;
        end else if (cnt_r == 4'd1) begin
          capture_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = EXEC;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // ALU operand registers and settle counter; operands persist through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= 4'd0;
      alu_a_r  <= 64'd0;
      alu_b_r  <= 64'd0;
      alu_op_r <= 6'd0;
    end else if (pop_s) begin
      cnt_r    <= 4'(SETTLE);
      alu_a_r  <= a_mem_r[rd_ptr_r];
      alu_b_r  <= b_mem_r[rd_ptr_r];
      alu_op_r <= op_mem_r[rd_ptr_r];
    end else if (state_r == EXEC) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result slot: raw ALU outputs are captured unmodified, including any x/z bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_c_r     <= 32'd0;
      out_flags_r <= 7'd0;
      out_op_r    <= 6'd0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      out_c_r     <= alu_c;
      out_flags_r <= alu_flags;
      out_op_r    <= alu_op_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready   = ~full_s;
  assign count      = count_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;
  assign alu_enable = (state_r == EXEC);
  assign out_valid  = out_valid_r;
  assign out_c      = out_c_r;
  assign out_flags  = out_flags_r;
  assign out_op     = out_op_r;

  alu_dispatch_checker #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .in_ready   (in_ready),
    .count      (count_r),
    .alu_enable (alu_enable),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a SETTLE=1 instance under directed and random traffic checked by a
// queue scoreboard, plus a SETTLE=3 instance for settle timing, flush-in-EXEC and async reset.
module tb_alu_dispatch;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [5:0]  op;
    logic [6:0]  flags;
    logic [31:0] c;
  } result_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          in_valid, in_ready, flush, alu_enable, out_valid, out_ready;
  logic [5:0]    in_op, alu_op, out_op;
  logic [63:0]   in_a, in_b, alu_a, alu_b;
  logic [31:0]   alu_c, out_c;
  logic [6:0]    alu_flags, out_flags;
  logic [CW-1:0] count;

  logic          in_valid3, in_ready3, flush3, alu_enable3, out_valid3, out_ready3;
  logic [5:0]    in_op3, alu_op3, out_op3;
  logic [63:0]   in_a3, in_b3, alu_a3, alu_b3;
  logic [31:0]   alu_c3, out_c3;
  logic [6:0]    alu_flags3, out_flags3;
  logic [CW-1:0] count3;

  int      tests = 0;
  int      fails = 0;
  result_t exp_q[$];
  int      en_run = 0;

  // Reference ALU: add/sub/mul plus a scrambling default; flags[4] is the 64-bit carry.
  function automatic result_t ref_alu(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] r;
    result_t     res;
    case (op)
      6'd1:    r = {1'b0, a} + {1'b0, b};
      6'd2:    r = {1'b0, a} - {1'b0, b};
      6'd5:    r = {1'b0, a * b};
      default: r = {1'b0, (a << 3) ^ b ^ {58'd0, op}};
    endcase
    res.c     = r[31:0];
    res.flags = {2'b00, r[64], r[63], 2'b00, (r[31:0] == 32'd0)};
    res.op    = op;
    return res;
  endfunction

  // Behavioural ALUs driven by the DUTs; garbage while disabled exposes mistimed captures.
  result_t alu_res, alu_res3;
  assign alu_res    = ref_alu(alu_op, alu_a, alu_b);
  assign alu_c      = alu_enable ? alu_res.c : 32'hA5A5_5A5A;
  assign alu_flags  = alu_enable ? alu_res.flags : 7'h55;
  assign alu_res3   = ref_alu(alu_op3, alu_a3, alu_b3);
  assign alu_c3     = alu_enable3 ? alu_res3.c : 32'hA5A5_5A5A;
  assign alu_flags3 = alu_enable3 ? alu_res3.flags : 7'h55;

  alu_dispatch #(.DEPTH(DEPTH), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_enable(alu_enable), .alu_c(alu_c), .alu_flags(alu_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_flags(out_flags), .out_op(out_op), .count(count)
  );

  alu_dispatch #(.DEPTH(DEPTH), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_op(in_op3),
    .in_a(in_a3), .in_b(in_b3), .flush(flush3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_enable(alu_enable3), .alu_c(alu_c3), .alu_flags(alu_flags3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_c(out_c3), .out_flags(out_flags3), .out_op(out_op3), .count(count3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted request queues its expected result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready && !flush) begin
      exp_q.push_back(ref_alu(in_op, in_a, in_b));
    end
  end

  // Monitor: compares each consumed result in order, applies flush/reset drops, times enable.
  always @(negedge clk) begin
    result_t e;
    int keep;
    if (rst) begin
      exp_q.delete();
      en_run = 0;
    end else begin
      if (alu_enable) begin
        en_run++;
      end else if (en_run != 0) begin
        check("enable_len", 64'(en_run), 64'd1);
        en_run = 0;
      end
      check("in_ready_vs_count", 64'(in_ready), 64'(count != CW'(DEPTH)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_out_c", 64'(out_c), 64'(e.c));
          check("sb_out_flags", 64'(out_flags), 64'(e.flags));
          check("sb_out_op", 64'(out_op), 64'(e.op));
        end
      end
      if (flush) begin
        keep = (out_valid && !out_ready) ? 1 : 0;
        while (exp_q.size() > keep) void'(exp_q.pop_back());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic rand_push1();
    push1(6'($urandom_range(0, 63)), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic drain1();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid && !alu_enable && count == CW'(0)) break;
      step();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_dut_idle", 64'({out_valid, alu_enable, count}), 64'd0);
  endtask

  // One SETTLE=3 transaction with enable-width and operand-stability checks.
  task automatic run3(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b, input string tag);
    result_t e;
    int      en_cycles;
    bit      got;
    e = ref_alu(op, a, b);
    en_cycles = 0;
    got = 1'b0;
    out_ready3 = 1'b0;
    in_valid3 = 1'b1; in_op3 = op; in_a3 = a; in_b3 = b;
    step();
    in_valid3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (alu_enable3) begin
        en_cycles++;
        check({tag, "_alu_a"}, alu_a3, a);
        check({tag, "_alu_b"}, alu_b3, b);
        check({tag, "_alu_op"}, 64'(alu_op3), 64'(op));
      end
      if (out_valid3) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_enable_cycles"}, 64'(en_cycles), 64'd3);
    check({tag, "_out_c"}, 64'(out_c3), 64'(e.c));
    check({tag, "_out_flags"}, 64'(out_flags3), 64'(e.flags));
    check({tag, "_out_op"}, 64'(out_op3), 64'(op));
    out_ready3 = 1'b1;
    step();
    out_ready3 = 1'b0;
    check({tag, "_slot_cleared"}, 64'(out_valid3), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = 6'd0; in_a = 64'd0; in_b = 64'd0; flush = 1'b0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_op3 = 6'd0; in_a3 = 64'd0; in_b3 = 64'd0; flush3 = 1'b0; out_ready3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu_enable", 64'(alu_enable), 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_alu_b", alu_b, 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_c", 64'(out_c), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_op", 64'(out_op), 64'd0);
    check("rst_alu_enable3", 64'(alu_enable3), 64'd0);
    rst = 1'b0;
    step();

    // Latency: accept at e, pop at e+1, result at e+2.
    out_ready = 1'b1;
    push1(6'd1, 64'd5, 64'd7);
    check("lat_count_after_accept", 64'(count), 64'd1);
    check("lat_enable_e0", 64'(alu_enable), 64'd0);
    step();
    check("lat_enable_e1", 64'(alu_enable), 64'd1);
    check("lat_alu_a", alu_a, 64'd5);
    check("lat_alu_b", alu_b, 64'd7);
    check("lat_alu_op", 64'(alu_op), 64'd1);
    check("lat_no_early_valid", 64'(out_valid), 64'd0);
    step();
    check("lat_enable_e2", 64'(alu_enable), 64'd0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_c", 64'(out_c), 64'd12);
    check("lat_flag4", 64'(out_flags[4]), 64'd0);
    check("lat_out_op", 64'(out_op), 64'd1);
    check("lat_alu_a_held", alu_a, 64'd5);
    step();
    check("lat_consumed", 64'(out_valid), 64'd0);

    // Back-pressure: one result parked in the slot, four buffered, sixth push refused.
    out_ready = 1'b0;
    repeat (5) rand_push1();
    step(); step();
    check("bp_count_full", 64'(count), 64'd4);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_slot_full", 64'(out_valid), 64'd1);
    check("bp_no_issue", 64'(alu_enable), 64'd0);
    rand_push1();
    check("bp_push_ignored", 64'(count), 64'd4);
    step();
    check("bp_still_full", 64'(count), 64'd4);
    drain1();

    // Push and pop on the same edge at count==2.
    out_ready = 1'b0;
    repeat (3) rand_push1();
    step(); step();
    check("pp_count_before", 64'(count), 64'd2);
    in_valid = 1'b1; in_op = 6'd2; in_a = 64'd1000; in_b = 64'd1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("pp_count_same", 64'(count), 64'd2);
    check("pp_issued", 64'(alu_enable), 64'd1);
    drain1();

    // Flush with a parked result and two queued requests; the parked result survives.
    out_ready = 1'b0;
    repeat (3) rand_push1();
    step(); step();
    check("fl_pre_count", 64'(count), 64'd2);
    check("fl_pre_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; in_valid = 1'b1; in_op = 6'd1; in_a = 64'd1; in_b = 64'd1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_slot_kept", 64'(out_valid), 64'd1);
    step(); step();
    check("fl_no_issue", 64'(alu_enable), 64'd0);
    check("fl_push_dropped", 64'(count), 64'd0);
    drain1();

    // Random traffic with occasional flushes; wraps the pointers many times.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_op     = 6'($urandom_range(0, 63));
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    drain1();

    // SETTLE=3 timing.
    run3(6'd5, 64'd3, 64'd4, "s3");

    // Flush during EXEC with two queued entries.
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; in_op3 = 6'd1; in_a3 = 64'd1; in_b3 = 64'd2;
    step();
    in_op3 = 6'd2; in_a3 = 64'd8; in_b3 = 64'd3;
    step();
    in_op3 = 6'd5; in_a3 = 64'd6; in_b3 = 64'd7;
    step();
    in_valid3 = 1'b0;
    check("f3_pre_enable", 64'(alu_enable3), 64'd1);
    check("f3_pre_count", 64'(count3), 64'd2);
    flush3 = 1'b1;
    step();
    flush3 = 1'b0;
    check("f3_enable_drop", 64'(alu_enable3), 64'd0);
    check("f3_count", 64'(count3), 64'd0);
    check("f3_no_capture", 64'(out_valid3), 64'd0);
    repeat (4) step();
    check("f3_still_idle", 64'(alu_enable3), 64'd0);
    check("f3_still_no_capture", 64'(out_valid3), 64'd0);
    out_ready3 = 1'b0;

    // Asynchronous reset between edges while u_dut3 executes and u_dut holds a result.
    out_ready = 1'b0;
    push1(6'd2, 64'd100, 64'd1);
    step(); step();
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; in_op3 = 6'd1; in_a3 = 64'd10; in_b3 = 64'd20;
    step();
    in_op3 = 6'd2; in_a3 = 64'd9; in_b3 = 64'd4;
    step();
    in_valid3 = 1'b0;
    check("ar_pre_enable3", 64'(alu_enable3), 64'd1);
    check("ar_pre_count3", 64'(count3), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_enable3", 64'(alu_enable3), 64'd0);
    check("ar_count3", 64'(count3), 64'd0);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready3", 64'(in_ready3), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready3 = 1'b0;
    step();
    run3(6'd5, 64'd3, 64'd4, "post_rst");
    drain1();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
